mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers, the sequential successor to the single-cycle ALU in the MIPS processor. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO over a start/busy/done handshake, stalling the pipeline while busy. HI/LO are always readable, so MFHI/MFLO need no operation. It sits beside the ALU in EX.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_iter_if.sv | 24 ++
 rtl/mdu_step.sv | 32 +++
 rtl/mdu_iter.sv | 140 ++++++++++++++
 tb/tb_mdu_iter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the iteration-counter width helper.
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } md_state_e;

  function automatic int md_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Start/busy/done handshake plus HI/LO read-out between the pipeline and mdu_iter.
interface mdu_iter_if #(parameter int WIDTH = 32);

  logic             mdStart;
  logic [2:0]       mdOp;
  logic [WIDTH-1:0] mdInA;
  logic [WIDTH-1:0] mdInB;
  logic             mdBusy;
  logic             mdDone;
  logic             mdDivZero;
  logic [WIDTH-1:0] mdHi;
  logic [WIDTH-1:0] mdLo;

  modport master (
    output mdStart, mdOp, mdInA, mdInB,
    input  mdBusy, mdDone, mdDivZero, mdHi, mdLo
  );

  modport slave (
    input  mdStart, mdOp, mdInA, mdInB,
    output mdBusy, mdDone, mdDivZero, mdHi, mdLo
  );

endinterface

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add multiply step or restoring
// shift-subtract divide step on a {hi, lo} working pair.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic           ge;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opb_i} : '0);
    shifted = {hi_i, lo_i[WIDTH-1]};
    ge      = (shifted >= {1'b0, opb_i});
    if (is_div_i) begin
      // Remainder stays below the divisor, so the difference fits in WIDTH bits.
      hi_o = ge ? (shifted[WIDTH-1:0] - opb_i) : shifted[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ge};
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with architectural HI/LO,
// sign-magnitude iteration and a final sign-fix cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rstN,
  mdu_iter_if.slave md
);

  localparam int CntW = md_cnt_w(WIDTH);

  md_state_e        state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opb_q;
  logic [WIDTH-1:0] acc_hi_d, acc_lo_d;
  logic             is_div_q, neg_q, rneg_q;
  logic             busy_q, done_q, dz_q;

  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  always_comb begin
    op_signed = (md.mdOp == MD_MULT) || (md.mdOp == MD_DIV);
    a_neg     = op_signed & md.mdInA[WIDTH-1];
    b_neg     = op_signed & md.mdInB[WIDTH-1];
    // Negating MIN yields the same bit pattern, read as unsigned 2^(WIDTH-1).
    a_mag     = a_neg ? -md.mdInA : md.mdInA;
    b_mag     = b_neg ? -md.mdInB : md.mdInB;
    prod      = {acc_hi_q, acc_lo_q};
    prod_fix  = neg_q ? -prod : prod;
    quot_fix  = neg_q ? -acc_lo_q : acc_lo_q;
    rem_fix   = rneg_q ? -acc_hi_q : acc_hi_q;
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .opb_i    (opb_q),
    .hi_o     (acc_hi_d),
    .lo_o     (acc_lo_d)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (md.mdStart) begin
            case (md.mdOp)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                if (md.mdOp[1] && (md.mdInB == '0)) begin
                  hi_q    <= md.mdInA;
                  lo_q    <= '1;
                  dz_q    <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= DONE;
                end else begin
                  // Multiply iterates over the multiplier in lo; divide over the dividend.
                  is_div_q <= md.mdOp[1];
                  acc_hi_q <= '0;
                  acc_lo_q <= md.mdOp[1] ? a_mag : b_mag;
                  opb_q    <= md.mdOp[1] ? b_mag : a_mag;
                  neg_q    <= a_neg ^ b_neg;
                  rneg_q   <= a_neg;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
                end
              end
              MD_MTHI: begin
                hi_q    <= md.mdInA;
                done_q  <= 1'b1;
                busy_q  <= 1'b1;
                state_q <= DONE;
              end
              MD_MTLO: begin
                lo_q    <= md.mdInA;
                done_q  <= 1'b1;
                busy_q  <= 1'b1;
                state_q <= DONE;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          if (is_div_q) begin
            lo_q <= quot_fix;
            hi_q <= rem_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md.mdBusy    = busy_q;
  assign md.mdDone    = done_q;
  assign md.mdDivZero = dz_q;
  assign md.mdHi      = hi_q;
  assign md.mdLo      = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized and directed bench for mdu_iter against a 64-bit arithmetic reference.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rstN;
  int   checks   = 0;
  int   failures = 0;
  logic [W-1:0] m_hi, m_lo;

  mdu_iter_if #(.WIDTH(W)) bus ();

  mdu_iter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .md   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; updates model HI/LO.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic exp_dz, output int exp_lat);
    longint sa, sb, res_q, res_r;
    logic [63:0] pv, qv, rv;
    bit sgn;
    sgn     = (op == MD_MULT) || (op == MD_DIV);
    sa      = sgn ? {{32{a[W-1]}}, a} : {32'b0, a};
    sb      = sgn ? {{32{b[W-1]}}, b} : {32'b0, b};
    exp_dz  = 1'b0;
    exp_lat = W + 2;
    case (op)
      MD_MULT, MD_MULTU: begin
        pv   = sa * sb;
        m_hi = pv[63:32];
        m_lo = pv[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b == '0) begin
          m_hi    = a;
          m_lo    = '1;
          exp_dz  = 1'b1;
          exp_lat = 1;
        end else begin
          res_q = sa / sb;
          res_r = sa % sb;
          qv    = res_q;
          rv    = res_r;
          m_lo  = qv[31:0];
          m_hi  = rv[31:0];
        end
      end
      MD_MTHI: begin m_hi = a; exp_lat = 1; end
      MD_MTLO: begin m_lo = a; exp_lat = 1; end
      default: exp_lat = 0;
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke);
    logic [W-1:0] prev_hi, prev_lo;
    logic exp_dz;
    int   exp_lat;
    int   cyc;
    prev_hi = m_hi;
    prev_lo = m_lo;
    model(op, a, b, exp_dz, exp_lat);
    bus.mdStart = 1'b1;
    bus.mdOp    = op;
    bus.mdInA   = a;
    bus.mdInB   = b;
    @(negedge clk);
    bus.mdStart = 1'b0;
    bus.mdOp    = 3'($urandom_range(0, 7));
    bus.mdInA   = $urandom;
    bus.mdInB   = $urandom;
    cyc = 1;
    while (!bus.mdDone && cyc < 60) begin
      if (cyc == 5) begin
        check({tag, "_busy_run"}, bus.mdBusy, 1);
        check({tag, "_hi_hold"}, bus.mdHi, prev_hi);
        check({tag, "_lo_hold"}, bus.mdLo, prev_lo);
      end
      if (poke && cyc == 10) begin
        bus.mdStart = 1'b1;
        bus.mdOp    = 3'($urandom_range(0, 5));
        bus.mdInA   = $urandom;
        bus.mdInB   = $urandom;
      end
      if (poke && cyc == 11) bus.mdStart = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_hi"}, bus.mdHi, m_hi);
    check({tag, "_lo"}, bus.mdLo, m_lo);
    check({tag, "_dz"}, bus.mdDivZero, exp_dz);
    check({tag, "_busy_done"}, bus.mdBusy, 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.mdDone, 0);
    check({tag, "_busy_clr"}, bus.mdBusy, 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.mdStart = 1'b0;
    bus.mdOp    = '0;
    bus.mdInA   = '0;
    bus.mdInB   = '0;
    m_hi        = '0;
    m_lo        = '0;
    rstN        = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.mdBusy, 0);
    check("rst_done", bus.mdDone, 0);
    check("rst_dz", bus.mdDivZero, 0);
    check("rst_hi", bus.mdHi, 0);
    check("rst_lo", bus.mdLo, 0);
    rstN = 1'b1;
    @(negedge clk);

    run_op("mult",  MD_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op("div_n7", MD_DIV,  32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu",  MD_DIVU,  32'd100, 32'd7, 0);
    run_op("div_min", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_z", MD_DIVU, 32'd5, 32'd0, 0);
    run_op("mthi",  MD_MTHI,  32'h0000_1234, 32'hDEAD_BEEF, 0);
    run_op("mtlo",  MD_MTLO,  32'h0000_ABCD, 32'hDEAD_BEEF, 0);
    run_op("poke",  MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1);

    bus.mdStart = 1'b1;
    bus.mdOp    = 3'b111;
    bus.mdInA   = 32'h5555_5555;
    @(negedge clk);
    bus.mdStart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("op7_done", bus.mdDone, 0);
      check("op7_busy", bus.mdBusy, 0);
      @(negedge clk);
    end
    check("op7_hi", bus.mdHi, m_hi);
    check("op7_lo", bus.mdLo, m_lo);

    bus.mdStart = 1'b1;
    bus.mdOp    = MD_MULT;
    bus.mdInA   = 32'h0001_0003;
    bus.mdInB   = 32'h0002_0005;
    @(negedge clk);
    bus.mdStart = 1'b0;
    repeat (9) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    check("arst_busy", bus.mdBusy, 0);
    check("arst_done", bus.mdDone, 0);
    check("arst_hi", bus.mdHi, 0);
    check("arst_lo", bus.mdLo, 0);
    @(negedge clk);
    rstN = 1'b1;
    m_hi = '0;
    m_lo = '0;
    repeat (2) begin
      @(negedge clk);
      check("arst_idle_done", bus.mdDone, 0);
    end
    run_op("post_rst", MD_MULT, 32'd3, 32'd5, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 5));
      run_op($sformatf("rnd%0d", i), op, pick(), pick(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
